// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, stall/flush handling
// and a saturating bubble counter.
module id_ex_stage #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [4:0]        in_rn,
   input  logic [4:0]        in_rm,
   input  logic [4:0]        in_rd,
   input  logic [DATA_W-1:0] in_rd1,
   input  logic [DATA_W-1:0] in_rd2,
   input  logic [DATA_W-1:0] in_imm,
   input  logic              in_use_imm,
   input  logic              in_reg_write,
   input  logic              ex_fwd_valid,
   input  logic [4:0]        ex_fwd_rd,
   input  logic [DATA_W-1:0] ex_fwd_data,
   input  logic              wb_fwd_valid,
   input  logic [4:0]        wb_fwd_rd,
   input  logic [DATA_W-1:0] wb_fwd_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_opa,
   output logic [DATA_W-1:0] out_opb,
   output logic [DATA_W-1:0] out_store,
   output logic [4:0]        out_rd,
   output logic              out_reg_write,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [4:0] ZERO_REG = 5'd31;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stateT;

   stateT             state;
   stateT             stateNxt;
   logic [DATA_W-1:0] srcA;
   logic [DATA_W-1:0] srcB;
   logic [4:0]        rnQ;
   logic [4:0]        rmQ;
   logic              useImmQ;
   logic              incBubble;
   logic              wbHit;

   // Register 31 reads as zero and is never a forwarding source; EX beats WB.
   function automatic logic [DATA_W-1:0] resolve(
      input logic [4:0]        r,
      input logic [DATA_W-1:0] rf,
      input logic              exV,
      input logic [4:0]        exR,
      input logic [DATA_W-1:0] exD,
      input logic              wbV,
      input logic [4:0]        wbR,
      input logic [DATA_W-1:0] wbD
   );
      logic [DATA_W-1:0] res;
      if (r == ZERO_REG)             res = '0;
      else if (exV && (exR == r))    res = exD;
      else if (wbV && (wbR == r))    res = wbD;
      else                           res = rf;
      return res;
   endfunction

   always_comb begin
      srcA = resolve(in_rn, in_rd1, ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                     wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
      srcB = resolve(in_rm, in_rd2, ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                     wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= EMPTY;
      else        state <= stateNxt;
   end

   always_comb begin
      stateNxt = state;
      if (flush)       stateNxt = EMPTY;
      else if (!stall) stateNxt = in_valid ? FULL : EMPTY;
   end

   assign out_valid = (state == FULL);

   // A held entry keeps absorbing the WB result, since the regfile it read is now stale.
   assign wbHit = (state == FULL) && wb_fwd_valid && (wb_fwd_rd != ZERO_REG);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_opa       <= '0;
         out_opb       <= '0;
         out_store     <= '0;
         out_rd        <= '0;
         out_reg_write <= 1'b0;
         rnQ           <= '0;
         rmQ           <= '0;
         useImmQ       <= 1'b0;
      end else if (flush) begin
         out_opa       <= '0;
         out_opb       <= '0;
         out_store     <= '0;
         out_rd        <= '0;
         out_reg_write <= 1'b0;
         rnQ           <= '0;
         rmQ           <= '0;
         useImmQ       <= 1'b0;
      end else if (!stall) begin
         out_opa       <= srcA;
         out_store     <= srcB;
         out_opb       <= in_use_imm ? in_imm : srcB;
         out_rd        <= in_rd;
         out_reg_write <= in_valid && in_reg_write && (in_rd != ZERO_REG);
         rnQ           <= in_rn;
         rmQ           <= in_rm;
         useImmQ       <= in_use_imm;
      end else if (wbHit) begin
         if (wb_fwd_rd == rnQ) out_opa <= wb_fwd_data;
         if (wb_fwd_rd == rmQ) begin
            out_store <= wb_fwd_data;
            if (!useImmQ) out_opb <= wb_fwd_data;
         end
      end
   end

   assign incBubble = flush || (!stall && !in_valid);

   // Saturating bubble counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                             bubble_cnt <= '0;
      else if (incBubble && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
   end

endmodule
